// File: rtl/button_debounce.sv
// Debounced push-button: 2-flop synchronizer, press/release debounce FSM, press counter.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press hold counter and LONG_HELD state.
module button_debounce #(
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned DEB_CYCLES  = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned LONG_CYCLES = (CLK_FREQ_HZ / 1000) * LONG_PRESS_MS;
  localparam int unsigned CNT_W       = $clog2(LONG_CYCLES + 1);
  // The IDLE/PRESSED sample that starts a debounce window counts as the first of DEB_CYCLES.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 2);
  localparam logic RELEASED = ACTIVE_LOW;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  typedef enum logic [2:0] {IDLE, PRESS_DEB, PRESSED, LONG_HELD, RELEASE_DEB} state_t;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             from_long_q, from_long_d;
  logic             long_pulse_q, long_pulse_d;
`else
  typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             btn_level_q, btn_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [7:0]       press_count_q, press_count_d;
  logic             s;

  assign s = sync2_q ^ RELEASED;

  always_comb begin
    sync1_d         = btn_in;
    sync2_d         = sync1_q;
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    press_count_d   = press_count_q;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    hold_d          = hold_q;
    from_long_d     = from_long_q;
    long_pulse_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d   = PRESS_DEB;
          deb_cnt_d = '0;
        end
      end
      PRESS_DEB: begin
        if (!s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d       = PRESSED;
          deb_cnt_d     = '0;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
          hold_d        = '0;
          from_long_d   = 1'b0;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d   = RELEASE_DEB;
          deb_cnt_d = '0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
          from_long_d = 1'b0;
        end else if (hold_q >= HOLD_LAST) begin
          state_d      = LONG_HELD;
          long_pulse_d = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
`endif
        end
      end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      LONG_HELD: begin
        if (!s) begin
          state_d     = RELEASE_DEB;
          deb_cnt_d   = '0;
          from_long_d = 1'b1;
        end
      end
`endif
      RELEASE_DEB: begin
        if (s) begin
          // Short release bounce: resume the originating state, hold count untouched.
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
          state_d = from_long_q ? LONG_HELD : PRESSED;
`else
          state_d = PRESSED;
`endif
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d         = IDLE;
          deb_cnt_d       = '0;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      deb_cnt_q       <= '0;
      sync1_q         <= RELEASED;
      sync2_q         <= RELEASED;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_count_q   <= '0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      hold_q          <= '0;
      from_long_q     <= 1'b0;
      long_pulse_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_count_q   <= press_count_d;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      hold_q          <= hold_d;
      from_long_q     <= from_long_d;
      long_pulse_q    <= long_pulse_d;
`endif
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = press_count_q;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  assign long_pulse    = long_pulse_q;
`else
  assign long_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: vector table, directed corner sequences, and random
// stimulus checked every cycle against a run-length reference model.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  button_debounce #(
    .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press = -1, last_rel = -1, last_long = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the debounced level flips after DEB consecutive synchronized
  // samples disagreeing with it; hold time counts agreeing pressed samples.
  logic       m_valid = 1'b0;
  logic       m_sync1, m_sync2, m_s, m_level, m_pp, m_rp, m_lp, m_long_done;
  int         m_run, m_hold;
  logic [7:0] m_cnt;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_sync1 = 1'b1; m_sync2 = 1'b1; m_level = 1'b0; m_run = 0; m_hold = 0;
      m_long_done = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0; m_cnt = 8'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_s = !m_sync2;
      m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
      if (m_s != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = m_s;
          m_run = 0;
          if (m_s) begin
            m_pp = 1'b1; m_cnt = m_cnt + 8'd1; m_hold = 0; m_long_done = 1'b0;
          end else begin
            m_rp = 1'b1;
          end
        end
      end else begin
        if (m_level && m_run == 0 && !m_long_done) begin
          m_hold++;
          if (m_hold == LONG) begin
            m_lp = LONG_EN;
            m_long_done = 1'b1;
          end
        end
        m_run = 0;
      end
      m_sync2 = m_sync1;
      m_sync1 = btn_in;
    end
  end

  always @(negedge clk) begin
    if (press_pulse)   begin n_press++; last_press = cyc; end
    if (release_pulse) begin n_rel++;   last_rel   = cyc; end
    if (long_pulse)    begin n_long++;  last_long  = cyc; end
    if (m_valid)
      check("model", int'({btn_level, press_pulse, release_pulse, long_pulse, press_count}),
            int'({m_level, m_pp, m_rp, m_lp, m_cnt}));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        btn;
    logic        rst;
    logic [11:0] exp;  // {level, press, release, long, count}
  } vec_t;

  vec_t tbl[20];
  int   t0, p0, r0, l0;

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 12'h000}, '{1'b1, 1'b1, 12'h000},
      '{1'b0, 1'b1, 12'h000}, '{1'b0, 1'b1, 12'h000}, '{1'b0, 1'b1, 12'h000},
      '{1'b0, 1'b1, 12'h000}, '{1'b0, 1'b1, 12'h000}, '{1'b0, 1'b1, 12'hC01},
      '{1'b0, 1'b1, 12'h801}, '{1'b0, 1'b1, 12'h801}, '{1'b0, 1'b1, 12'h801},
      '{1'b0, 1'b1, 12'h801}, '{1'b1, 1'b1, 12'h801}, '{1'b1, 1'b1, 12'h801},
      '{1'b1, 1'b1, 12'h801}, '{1'b1, 1'b1, 12'h801}, '{1'b1, 1'b1, 12'h801},
      '{1'b1, 1'b1, 12'h201}, '{1'b1, 1'b1, 12'h001}, '{1'b1, 1'b1, 12'h001}
    };
    step(2);

    // Clean press and release, cycle by cycle
    for (int i = 0; i < 20; i++) begin
      btn_in = tbl[i].btn;
      rst_n  = tbl[i].rst;
      step(1);
      check($sformatf("vec%0d", i),
            int'({btn_level, press_pulse, release_pulse, long_pulse, press_count}),
            int'(tbl[i].exp));
    end
    step(4);

    // Bounce: low 3, high 1, then low steady
    p0 = n_press;
    btn_in = 1'b0; step(3);
    btn_in = 1'b1; step(1);
    btn_in = 1'b0; t0 = cyc;
    step(20);
    check("bounce_presses", n_press - p0, 1);
    check("bounce_latency", last_press - t0, 6);
    btn_in = 1'b1; step(12);

    // Long press: hold 30 cycles then release
    l0 = n_long;
    btn_in = 1'b0; t0 = cyc;
    step(30);
    check("long_press_latency", last_press - t0, 6);
    check("long_count", n_long - l0, LONG_EN ? 1 : 0);
    if (LONG_EN) check("long_after_press", last_long - last_press, 20);
    btn_in = 1'b1; t0 = cyc;
    step(12);
    check("long_release_latency", last_rel - t0, 6);
    check("long_count_after_release", n_long - l0, LONG_EN ? 1 : 0);

    // Reset while pressed, button still held
    btn_in = 1'b0; step(10);
    check("held_level", int'(btn_level), 1);
    r0 = n_rel;
    rst_n = 1'b0; step(1);
    check("reset_outputs",
          int'({btn_level, press_pulse, release_pulse, long_pulse, press_count}), 0);
    rst_n = 1'b1; t0 = cyc;
    step(10);
    check("reset_no_release", n_rel - r0, 0);
    check("reset_repress_latency", last_press - t0, 6);
    check("reset_repress_count", int'(press_count), 1);
    btn_in = 1'b1; step(12);

    // press_count wrap after 256 presses
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; step(4);
    p0 = n_press; r0 = n_rel;
    for (int i = 0; i < 256; i++) begin
      btn_in = 1'b0; step(8);
      btn_in = 1'b1; step(8);
      if (i == 254) check("count_255", int'(press_count), 255);
    end
    check("wrap_count", int'(press_count), 0);
    check("wrap_presses", n_press - p0, 256);
    check("wrap_releases", n_rel - r0, 256);

    // Random bouncing with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0; step($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      btn_in = 1'($urandom_range(0, 1));
      step($urandom_range(1, ($urandom_range(0, 3) == 0) ? 30 : 8));
    end
    btn_in = 1'b1; step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
